// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters,
// with a one-entry registered response buffer per port and a contention counter.
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4,
  parameter int SHW   = 5,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [WIDTH-1:0] r0_a,
  input  logic [WIDTH-1:0] r0_b,
  input  logic [SHW-1:0]   r0_shamt,
  input  logic [OPW-1:0]   r0_op,
  output logic             r0_rsp_valid,
  input  logic             r0_rsp_ready,
  output logic [WIDTH-1:0] r0_res,
  output logic             r0_zero,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [WIDTH-1:0] r1_a,
  input  logic [WIDTH-1:0] r1_b,
  input  logic [SHW-1:0]   r1_shamt,
  input  logic [OPW-1:0]   r1_op,
  output logic             r1_rsp_valid,
  input  logic             r1_rsp_ready,
  output logic [WIDTH-1:0] r1_res,
  output logic             r1_zero,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [SHW-1:0]   alu_shamt,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_zero,
  output logic             gnt_valid,
  output logic             gnt_id,
  output logic [CNTW-1:0]  conflict_cnt
);

  // Handshakes: a request transfers on an edge where valid && ready; a response
  // is consumed on an edge where rsp_valid && rsp_ready. A slot drained in the
  // same cycle counts as free, so one port can sustain one request per cycle.
  logic             r0_rsp_valid_q, r0_rsp_valid_d;
  logic             r1_rsp_valid_q, r1_rsp_valid_d;
  logic [WIDTH-1:0] r0_res_q, r0_res_d, r1_res_q, r1_res_d;
  logic             r0_zero_q, r0_zero_d, r1_zero_q, r1_zero_d;
  logic             last_grant_q, last_grant_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;

  logic slot_free0, slot_free1, elig0, elig1, xfer0, xfer1;

  always_comb begin
    slot_free0 = !r0_rsp_valid_q || r0_rsp_ready;
    slot_free1 = !r1_rsp_valid_q || r1_rsp_ready;
    elig0      = r0_valid && slot_free0;
    elig1      = r1_valid && slot_free1;
    gnt_valid  = elig0 || elig1;
    // Idle cycles keep pointing at the last winner so the mux stays put.
    if (elig0 && elig1)  gnt_id = !last_grant_q;
    else if (elig1)      gnt_id = 1'b1;
    else if (elig0)      gnt_id = 1'b0;
    else                 gnt_id = last_grant_q;
    r0_ready = gnt_valid && !gnt_id;
    r1_ready = gnt_valid && gnt_id;
    xfer0    = r0_valid && r0_ready;
    xfer1    = r1_valid && r1_ready;
  end

  always_comb begin
    alu_a     = gnt_id ? r1_a     : r0_a;
    alu_b     = gnt_id ? r1_b     : r0_b;
    alu_shamt = gnt_id ? r1_shamt : r0_shamt;
    alu_op    = gnt_id ? r1_op    : r0_op;
  end

  always_comb begin
    r0_rsp_valid_d = r0_rsp_valid_q && !r0_rsp_ready;
    r0_res_d       = r0_res_q;
    r0_zero_d      = r0_zero_q;
    r1_rsp_valid_d = r1_rsp_valid_q && !r1_rsp_ready;
    r1_res_d       = r1_res_q;
    r1_zero_d      = r1_zero_q;
    last_grant_d   = last_grant_q;
    if (xfer0) begin
      r0_rsp_valid_d = 1'b1;
      r0_res_d       = alu_res;
      r0_zero_d      = alu_zero;
      last_grant_d   = 1'b0;
    end
    if (xfer1) begin
      r1_rsp_valid_d = 1'b1;
      r1_res_d       = alu_res;
      r1_zero_d      = alu_zero;
      last_grant_d   = 1'b1;
    end
    cnt_d = cnt_q;
    if (elig0 && elig1 && (cnt_q != {CNTW{1'b1}})) cnt_d = cnt_q + CNTW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r0_rsp_valid_q <= 1'b0;
      r1_rsp_valid_q <= 1'b0;
      r0_res_q       <= '0;
      r1_res_q       <= '0;
      r0_zero_q      <= 1'b0;
      r1_zero_q      <= 1'b0;
      last_grant_q   <= 1'b1;
      cnt_q          <= '0;
    end else begin
      r0_rsp_valid_q <= r0_rsp_valid_d;
      r1_rsp_valid_q <= r1_rsp_valid_d;
      r0_res_q       <= r0_res_d;
      r1_res_q       <= r1_res_d;
      r0_zero_q      <= r0_zero_d;
      r1_zero_q      <= r1_zero_d;
      last_grant_q   <= last_grant_d;
      cnt_q          <= cnt_d;
    end
  end

  assign r0_rsp_valid = r0_rsp_valid_q;
  assign r1_rsp_valid = r1_rsp_valid_q;
  assign r0_res       = r0_res_q;
  assign r1_res       = r1_res_q;
  assign r0_zero      = r0_zero_q;
  assign r1_zero      = r1_zero_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios then constrained-random traffic,
// checked against a per-port response-queue model with a local ALU.
module tb_alu_arbiter;
  localparam int W = 32;
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3,
                         OP_XOR = 4'd4, OP_SLL = 4'd5, OP_SRL = 4'd6, OP_BNE = 4'd7;

  logic clk = 1'b0;
  logic rst_n;
  logic r0_valid, r0_ready, r0_rsp_valid, r0_rsp_ready, r0_zero;
  logic r1_valid, r1_ready, r1_rsp_valid, r1_rsp_ready, r1_zero;
  logic [W-1:0] r0_a, r0_b, r1_a, r1_b, r0_res, r1_res;
  logic [4:0] r0_shamt, r1_shamt, alu_shamt, s_alu_shamt;
  logic [3:0] r0_op, r1_op, alu_op, s_alu_op;
  logic [W-1:0] alu_a, alu_b, alu_res, s_alu_a, s_alu_b, s_alu_res;
  logic alu_zero, s_alu_zero, gnt_valid, gnt_id, s_gnt_valid, s_gnt_id;
  logic [15:0] conflict_cnt;
  logic s_r0_ready, s_r1_ready, s_r0_rsp_valid, s_r1_rsp_valid, s_r0_zero, s_r1_zero;
  logic [W-1:0] s_r0_res, s_r1_res;
  logic [1:0] sat_cnt;

  always #5 clk = ~clk;

  function automatic logic [W:0] alu_f(input logic [3:0] op, input logic [W-1:0] a,
                                       input logic [W-1:0] b, input logic [4:0] sh);
    logic [W-1:0] r;
    case (op)
      OP_ADD: r = a + b;
      OP_SUB: r = a - b;
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_SLL: r = b << sh;
      OP_SRL: r = b >> sh;
      default: r = a - b;
    endcase
    if (op == OP_BNE) return {a != b, r};
    return {r == '0, r};
  endfunction

  assign {alu_zero, alu_res}     = alu_f(alu_op, alu_a, alu_b, alu_shamt);
  assign {s_alu_zero, s_alu_res} = alu_f(s_alu_op, s_alu_a, s_alu_b, s_alu_shamt);

  alu_arbiter #(.WIDTH(W), .OPW(4), .SHW(5), .CNTW(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b),
    .r0_shamt(r0_shamt), .r0_op(r0_op), .r0_rsp_valid(r0_rsp_valid),
    .r0_rsp_ready(r0_rsp_ready), .r0_res(r0_res), .r0_zero(r0_zero),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b),
    .r1_shamt(r1_shamt), .r1_op(r1_op), .r1_rsp_valid(r1_rsp_valid),
    .r1_rsp_ready(r1_rsp_ready), .r1_res(r1_res), .r1_zero(r1_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_shamt(alu_shamt), .alu_op(alu_op),
    .alu_res(alu_res), .alu_zero(alu_zero),
    .gnt_valid(gnt_valid), .gnt_id(gnt_id), .conflict_cnt(conflict_cnt)
  );

  // Narrow-counter instance, driven by the same requesters, to observe saturation.
  alu_arbiter #(.WIDTH(W), .OPW(4), .SHW(5), .CNTW(2)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(r0_valid), .r0_ready(s_r0_ready), .r0_a(r0_a), .r0_b(r0_b),
    .r0_shamt(r0_shamt), .r0_op(r0_op), .r0_rsp_valid(s_r0_rsp_valid),
    .r0_rsp_ready(r0_rsp_ready), .r0_res(s_r0_res), .r0_zero(s_r0_zero),
    .r1_valid(r1_valid), .r1_ready(s_r1_ready), .r1_a(r1_a), .r1_b(r1_b),
    .r1_shamt(r1_shamt), .r1_op(r1_op), .r1_rsp_valid(s_r1_rsp_valid),
    .r1_rsp_ready(r1_rsp_ready), .r1_res(s_r1_res), .r1_zero(s_r1_zero),
    .alu_a(s_alu_a), .alu_b(s_alu_b), .alu_shamt(s_alu_shamt), .alu_op(s_alu_op),
    .alu_res(s_alu_res), .alu_zero(s_alu_zero),
    .gnt_valid(s_gnt_valid), .gnt_id(s_gnt_id), .conflict_cnt(sat_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: pending-response queues per port plus arbitration history.
  logic [W:0] exp_q0[$], exp_q1[$];
  logic [W-1:0] m_res0, m_res1;
  logic m_zero0, m_zero1, m_last;
  int m_cnt;
  logic obs_r0_ready, obs_r1_ready, obs_gnt_id;
  logic acc0, acc1;
  int acc_n0, acc_n1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q0.delete(); exp_q1.delete();
    m_res0 = '0; m_res1 = '0; m_zero0 = 1'b0; m_zero1 = 1'b0;
    m_last = 1'b1; m_cnt = 0;
  endtask

  task automatic step();
    logic e0, e1, win, any;
    logic [W:0] v;
    @(negedge clk);
    e0 = r0_valid && (exp_q0.size() == 0 || r0_rsp_ready);
    e1 = r1_valid && (exp_q1.size() == 0 || r1_rsp_ready);
    any = e0 || e1;
    if (e0 && e1) win = !m_last;
    else win = e1 ? 1'b1 : (e0 ? 1'b0 : m_last);
    acc0 = any && !win;
    acc1 = any && win;
    obs_r0_ready = r0_ready; obs_r1_ready = r1_ready; obs_gnt_id = gnt_id;
    check("gnt_valid", gnt_valid, any);
    check("gnt_id", gnt_id, win);
    check("r0_ready", r0_ready, acc0);
    check("r1_ready", r1_ready, acc1);
    check("alu_a", alu_a, win ? r1_a : r0_a);
    check("alu_b", alu_b, win ? r1_b : r0_b);
    check("alu_op", alu_op, win ? r1_op : r0_op);
    check("alu_shamt", alu_shamt, win ? r1_shamt : r0_shamt);
    if (exp_q0.size() != 0 && r0_rsp_ready) begin
      v = exp_q0.pop_front();
      check("r0_drain_data", {r0_zero, r0_res}, v);
    end
    if (exp_q1.size() != 0 && r1_rsp_ready) begin
      v = exp_q1.pop_front();
      check("r1_drain_data", {r1_zero, r1_res}, v);
    end
    if (!rst_n) model_reset();
    else begin
      if (acc0) begin
        v = alu_f(r0_op, r0_a, r0_b, r0_shamt);
        exp_q0.push_back(v); {m_zero0, m_res0} = v; m_last = 1'b0;
      end
      if (acc1) begin
        v = alu_f(r1_op, r1_a, r1_b, r1_shamt);
        exp_q1.push_back(v); {m_zero1, m_res1} = v; m_last = 1'b1;
      end
      if (e0 && e1 && m_cnt < 65535) m_cnt++;
    end
    @(posedge clk);
    #1;
    check("r0_rsp_valid", r0_rsp_valid, exp_q0.size() != 0);
    check("r1_rsp_valid", r1_rsp_valid, exp_q1.size() != 0);
    check("r0_res", {r0_zero, r0_res}, {m_zero0, m_res0});
    check("r1_res", {r1_zero, r1_res}, {m_zero1, m_res1});
    check("conflict_cnt", conflict_cnt, m_cnt);
    check("sat_cnt", sat_cnt, (m_cnt > 3) ? 3 : m_cnt);
  endtask

  task automatic req0(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [4:0] sh);
    r0_valid = 1'b1; r0_op = op; r0_a = a; r0_b = b; r0_shamt = sh;
  endtask

  task automatic req1(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [4:0] sh);
    r1_valid = 1'b1; r1_op = op; r1_a = a; r1_b = b; r1_shamt = sh;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    r0_valid = 0; r0_a = 0; r0_b = 0; r0_shamt = 0; r0_op = 0; r0_rsp_ready = 1;
    r1_valid = 0; r1_a = 0; r1_b = 0; r1_shamt = 0; r1_op = 0; r1_rsp_ready = 1;
    model_reset();
    step(); step();
    rst_n = 1'b1;
    check("rst_r0_rsp_valid", r0_rsp_valid, 0);
    check("rst_r1_res", r1_res, 0);
    check("rst_cnt", conflict_cnt, 0);
    check("rst_gnt_id_idle", gnt_id, 1);

    // Single request on port 0.
    req0(OP_ADD, 5, 7, 0);
    step();
    r0_valid = 0;
    check("t1_ready", obs_r0_ready, 1);
    check("t1_res", r0_res, 12);
    check("t1_zero", r0_zero, 0);
    check("t1_rsp_valid", r0_rsp_valid, 1);
    check("t1_r1_untouched", r1_rsp_valid, 0);
    step();

    // First tie after reset goes to port 0.
    do_reset();
    req0(OP_SUB, 9, 9, 0);
    req1(OP_OR, 32'hF0, 32'h0F, 0);
    step();
    r0_valid = 0;
    check("t2_first_gnt", obs_gnt_id, 0);
    check("t2_r0_res", r0_res, 0);
    check("t2_r0_zero", r0_zero, 1);
    step();
    r1_valid = 0;
    check("t2_second_gnt", obs_gnt_id, 1);
    check("t2_r1_res", r1_res, 32'hFF);
    check("t2_cnt", conflict_cnt, 1);
    step();

    // Sustained contention alternates grants.
    do_reset();
    acc_n0 = 0; acc_n1 = 0;
    req0(4'($urandom_range(0, 7)), $urandom, $urandom, 5'($urandom_range(0, 31)));
    req1(4'($urandom_range(0, 7)), $urandom, $urandom, 5'($urandom_range(0, 31)));
    for (int i = 0; i < 10; i++) begin
      step();
      check("t3_alternate", obs_gnt_id, i % 2);
      if (obs_r0_ready) begin
        acc_n0++;
        req0(4'($urandom_range(0, 7)), $urandom, $urandom, 5'($urandom_range(0, 31)));
      end
      if (obs_r1_ready) begin
        acc_n1++;
        req1(4'($urandom_range(0, 7)), $urandom, $urandom, 5'($urandom_range(0, 31)));
      end
      if (i == 5) check("t6_sat_stop", sat_cnt, 3);
    end
    check("t3_acc0", acc_n0, 5);
    check("t3_acc1", acc_n1, 5);
    check("t3_cnt", conflict_cnt, 10);
    check("t6_sat_final", sat_cnt, 3);
    r0_valid = 0; r1_valid = 0;
    step();

    // Backpressure on port 0 lets port 1 through.
    r0_rsp_ready = 0;
    req0(OP_ADD, 1, 1, 0);
    step();
    req0(OP_ADD, 2, 3, 0);
    req1(OP_SLL, 0, 1, 4);
    step();
    r1_valid = 0;
    check("t4_r0_blocked", obs_r0_ready, 0);
    check("t4_r1_gnt", obs_r1_ready, 1);
    check("t4_r1_res", r1_res, 16);
    check("t4_r0_hold", r0_res, 2);
    step();
    check("t4_r0_still_blocked", obs_r0_ready, 0);
    check("t4_r0_hold2", r0_res, 2);
    r0_rsp_ready = 1;
    step();
    r0_valid = 0;
    check("t4_r0_accept", obs_r0_ready, 1);
    check("t4_r0_new", r0_res, 5);
    step();

    // BNE zero sense, then reset discards pending state.
    r1_rsp_ready = 0;
    req1(OP_BNE, 3, 4, 0);
    step();
    r1_valid = 0;
    check("t5_bne_zero", r1_zero, 1);
    check("t5_bne_res", r1_res, 32'hFFFF_FFFF);
    rst_n = 0;
    req0(OP_ADD, 8, 8, 0);
    step();
    rst_n = 1; r0_valid = 0; r1_rsp_ready = 1;
    check("t5_r0_rsp_valid", r0_rsp_valid, 0);
    check("t5_r1_rsp_valid", r1_rsp_valid, 0);
    check("t5_r1_res", r1_res, 0);
    check("t5_r1_zero", r1_zero, 0);
    check("t5_cnt", conflict_cnt, 0);
    step();

    // Random traffic; requesters hold fields until accepted.
    for (int i = 0; i < 400; i++) begin
      if (!r0_valid || acc0) begin
        r0_valid = ($urandom_range(0, 3) != 0);
        r0_op = 4'($urandom_range(0, 7)); r0_a = $urandom; r0_b = $urandom;
        r0_shamt = 5'($urandom_range(0, 31));
        if ($urandom_range(0, 3) == 0) r0_b = r0_a;
      end
      if (!r1_valid || acc1) begin
        r1_valid = ($urandom_range(0, 3) != 0);
        r1_op = 4'($urandom_range(0, 7)); r1_a = $urandom; r1_b = $urandom;
        r1_shamt = 5'($urandom_range(0, 31));
      end
      r0_rsp_ready = ($urandom_range(0, 3) != 0);
      r1_rsp_ready = ($urandom_range(0, 3) != 0);
      rst_n = ($urandom_range(0, 99) != 0);
      acc0 = 1'b0; acc1 = 1'b0;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
